// File: rtl/rv_imem_arb.sv
// Instruction-memory arbiter: a boot loader owns the port in BOOT, then the core fetch path shares it in RUN.
// Optional round-robin contention arbitration in RUN is enabled by defining RV_IMEM_ARB_RR_EN.
module rv_imem_arb #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          fetch_req_i,
   input  logic [AW-1:0] fetch_addr_i,
   output logic          fetch_gnt_o,
   output logic          fetch_rvalid_o,
   output logic [DW-1:0] fetch_rdata_o,
   input  logic          ld_req_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [DW-1:0] ld_wdata_i,
   output logic          ld_gnt_o,
   input  logic          ld_done_i,
   output logic          boot_done_o,
   output logic [AW:0]   ld_cnt_o,
   output logic [AW-1:0] mem_addr_o,
   output logic          mem_we_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   // Handshake: a grant is a same-cycle combinational accept of req; fetch data follows one cycle later
   // with fetch_rvalid_o, and there is no backpressure on the response.
   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

   localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

   state_e        state_q, state_d;
   logic          fetch_gnt, ld_gnt;
   logic          rvalid_q, rvalid_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= BOOT;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == BOOT && ld_done_i) state_d = RUN;
   end

`ifdef RV_IMEM_ARB_RR_EN
   // rr_ptr_q = 1 means the loader wins the next contended cycle.
   logic rr_ptr_q, rr_ptr_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rr_ptr_q <= 1'b0;
      else          rr_ptr_q <= rr_ptr_d;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == RUN && fetch_req_i && ld_req_i) rr_ptr_d = fetch_gnt;
   end
`endif

   always_comb begin
      fetch_gnt = 1'b0;
      ld_gnt    = 1'b0;
      if (rst_n_i) begin
         case (state_q)
            BOOT: ld_gnt = ld_req_i;
            RUN: begin
               if (fetch_req_i && ld_req_i) begin
`ifdef RV_IMEM_ARB_RR_EN
                  fetch_gnt = ~rr_ptr_q;
                  ld_gnt    = rr_ptr_q;
`else
                  fetch_gnt = 1'b1;
`endif
               end else begin
                  fetch_gnt = fetch_req_i;
                  ld_gnt    = ld_req_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      addr_d   = addr_q;
      if (fetch_gnt)   addr_d = fetch_addr_i;
      else if (ld_gnt) addr_d = ld_addr_i;
      rvalid_d = fetch_gnt;
      cnt_d    = cnt_q;
      if (ld_gnt && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rvalid_q <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
      end
   end

   assign fetch_gnt_o    = fetch_gnt;
   assign ld_gnt_o       = ld_gnt;
   assign fetch_rvalid_o = rvalid_q;
   assign fetch_rdata_o  = mem_rdata_i;
   assign boot_done_o    = (state_q == RUN);
   assign ld_cnt_o       = cnt_q;
   assign mem_addr_o     = addr_d;
   assign mem_we_o       = ld_gnt;
   assign mem_wdata_o    = ld_wdata_i;

endmodule

// File: tb/tb_rv_imem_arb.sv
// Directed bench for rv_imem_arb with a behavioural synchronous memory and an expected-data queue
// drained by an independent monitor on fetch_rvalid_o.
module tb_rv_imem_arb;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_gnt, fetch_rvalid;
   logic [DW-1:0] fetch_rdata;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt, ld_done, boot_done;
   logic [AW:0]   ld_cnt;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] exp_q[$];
   int            n_cmp  = 0;
   int            n_fail = 0;

   rv_imem_arb #(.AW(AW), .DW(DW)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
      .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
      .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_gnt_o(ld_gnt),
      .ld_done_i(ld_done), .boot_done_o(boot_done), .ld_cnt_o(ld_cnt),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // clock / memory model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every response must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && fetch_rvalid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rdata_unexpected: got rvalid with data %0h expected no response", fetch_rdata);
         end else begin
            check("rdata", fetch_rdata, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr,
                        input logic [AW-1:0] la, input logic [DW-1:0] lw, input logic ld);
      fetch_req  = fr;
      fetch_addr = fa;
      ld_req     = lr;
      ld_addr    = la;
      ld_wdata   = lw;
      ld_done    = ld;
   endtask

   task automatic cycle(input logic efg, input logic elg, input logic [DW-1:0] edata, input string tag);
      @(negedge clk);
      check({tag, "_fetch_gnt"}, fetch_gnt, efg);
      check({tag, "_ld_gnt"}, ld_gnt, elg);
      check({tag, "_one_grant"}, fetch_gnt & ld_gnt, 0);
      if (efg) begin
         exp_q.push_back(edata);
         check({tag, "_fetch_addr"}, mem_addr, fetch_addr);
         check({tag, "_fetch_we"}, mem_we, 0);
      end
      if (elg) begin
         check({tag, "_ld_addr"}, mem_addr, ld_addr);
         check({tag, "_ld_we"}, mem_we, 1);
         check({tag, "_ld_wdata"}, mem_wdata, ld_wdata);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] boot_img [3];
      logic          exp_f [4];
      int            exp_cnt;
      boot_img[0] = 32'h0000_0013;
      boot_img[1] = 32'h0010_0093;
      boot_img[2] = 32'h0020_8113;
`ifdef RV_IMEM_ARB_RR_EN
      exp_f[0] = 1'b1; exp_f[1] = 1'b0; exp_f[2] = 1'b1; exp_f[3] = 1'b0;
`else
      exp_f[0] = 1'b1; exp_f[1] = 1'b1; exp_f[2] = 1'b1; exp_f[3] = 1'b1;
`endif
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      mem_rdata = '0;

      // reset state with both requesters active
      rst_n = 1'b0;
      drive(1'b1, 5'd3, 1'b1, 5'd4, 32'h1111_1111, 1'b0);
      @(negedge clk);
      check("rst_fetch_gnt", fetch_gnt, 0);
      check("rst_ld_gnt", ld_gnt, 0);
      check("rst_rvalid", fetch_rvalid, 0);
      check("rst_boot_done", boot_done, 0);
      check("rst_ld_cnt", ld_cnt, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", mem_we, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // BOOT: fetches are refused
      drive(1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 32'h0, "boot_fetch");
         check("boot_fetch_rvalid", fetch_rvalid, 0);
      end

      // BOOT: load image, done pulse coincides with the last write
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd0, 1'b1, 5'(i), boot_img[i], i == 2);
         cycle(1'b0, 1'b1, 32'h0, "boot_load");
      end
      drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      check("load_ld_cnt", ld_cnt, 3);
      check("load_boot_done", boot_done, 1);
      exp_cnt = 3;

      // RUN: back-to-back fetches
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(i), 1'b0, 5'd0, 32'h0, 1'b0);
         cycle(1'b1, 1'b0, boot_img[i], "run_fetch");
      end

      // RUN: done pulse ignored
      drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, "run_done_pulse");
      check("run_boot_done_kept", boot_done, 1);

      // RUN: contention
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd1, 1'b1, 5'd10, 32'hA5A5_0000 + 32'(i), 1'b0);
         cycle(exp_f[i], ~exp_f[i], boot_img[1], "contend");
         if (!exp_f[i]) exp_cnt++;
      end
      check("contend_ld_cnt", ld_cnt, exp_cnt);

      // RUN: write then fetch same address, then idle holds the address
      drive(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
      cycle(1'b0, 1'b1, 32'h0, "raw_write");
      exp_cnt++;
      drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 32'hDEAD_BEEF, "raw_fetch");
      drive(1'b0, 5'd9, 1'b0, 5'd7, 32'h0, 1'b0);
      @(negedge clk);
      check("idle_addr_hold", mem_addr, 5);
      check("idle_ld_cnt", ld_cnt, exp_cnt);
      @(posedge clk); #1;

      // reset in the cycle after a fetch grant
      drive(1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, boot_img[0], "pre_reset_fetch");
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_rvalid", fetch_rvalid, 0);
      check("midrst_boot_done", boot_done, 0);
      check("midrst_ld_cnt", ld_cnt, 0);
      @(negedge clk);
      check("midrst_fetch_gnt", fetch_gnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, "post_reset_idle");

      // BOOT: counter saturation
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0);
         cycle(1'b0, 1'b1, 32'h0, "sat_load");
         check("sat_ld_cnt", ld_cnt, (i + 1 > 32) ? 32 : i + 1);
      end
      drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rv_imem_arb.md
RV_IMEM_ARB -- requirements
Module: rv_imem_arb

Interface
REQ-001 Parameter AW, default 5, instruction-memory word-address width (32 words).
REQ-002 Parameter DW, default 32, instruction word width.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 fetch_req_i  input  1  core fetch request.
REQ-006 fetch_addr_i  input  AW  fetch word address.
REQ-007 fetch_gnt_o  output  1  fetch accepted this cycle.
REQ-008 fetch_rvalid_o  output  1  fetch data valid; asserted the cycle after the grant.
REQ-009 fetch_rdata_o  output  DW  fetched instruction.
REQ-010 ld_req_i  input  1  loader write request.
REQ-011 ld_addr_i  input  AW  loader word address.
REQ-012 ld_wdata_i  input  DW  loader write data.
REQ-013 ld_gnt_o  output  1  loader write accepted this cycle.
REQ-014 ld_done_i  input  1  one-cycle pulse; loader finished boot image.
REQ-015 boot_done_o  output  1  high while in RUN state.
REQ-016 ld_cnt_o  output  AW+1  number of accepted loader writes.
REQ-017 mem_addr_o  output  AW  single-port memory address.
REQ-018 mem_we_o  output  1  memory write enable.
REQ-019 mem_wdata_o  output  DW  memory write data.
REQ-020 mem_rdata_i  input  DW  memory read data; synchronous, valid one cycle after the address.

Function
REQ-021 The FSM SHALL have two states: BOOT (entered on reset) and RUN.
REQ-022 BOOT: fetch_gnt_o SHALL be 0; ld_gnt_o SHALL equal ld_req_i.
REQ-023 BOOT -> RUN SHALL occur on the clock edge where ld_done_i=1; a write requested in that same cycle SHALL still be granted.
REQ-024 RUN is terminal until reset; ld_done_i SHALL be ignored in RUN.
REQ-025 RUN, single requester: that requester SHALL be granted in the same cycle (combinational grant).
REQ-026 RUN, both requesting: fetch SHALL win (fixed priority) unless RV_IMEM_ARB_RR_EN is defined.
REQ-027 At most one grant SHALL be asserted per cycle.
REQ-028 mem_addr_o SHALL be the granted requester's address; with no grant, it SHALL hold its registered last value.
REQ-029 mem_we_o SHALL equal ld_gnt_o; mem_wdata_o SHALL equal ld_wdata_i.
REQ-030 fetch_rvalid_o SHALL be a register of fetch_gnt_o (1-cycle latency); fetch_rdata_o SHALL equal mem_rdata_i.
REQ-031 Back-to-back fetches SHALL sustain one grant per cycle, with no bubbles.
REQ-032 ld_cnt_o SHALL increment on each ld_gnt_o and saturate at 2^AW.
REQ-033 A loader write followed by a fetch to the same address in the next cycle SHALL return the new data.

Reset
REQ-034 rst_n_i low SHALL immediately force: state BOOT, fetch_rvalid_o=0, boot_done_o=0, ld_cnt_o=0, registered mem_addr_o=0, RR pointer = fetch-preferred.
REQ-035 Reset asserted mid-fetch SHALL drop the pending rvalid; no response SHALL appear after release.
REQ-036 Grants SHALL be 0 while rst_n_i is low.

Configuration
REQ-037 Macro RV_IMEM_ARB_RR_EN defined: RUN contention SHALL use round-robin, granting the requester not granted at the last contended cycle; the first contention SHALL go to fetch.
REQ-038 RV_IMEM_ARB_RR_EN undefined: fixed priority fetch > loader SHALL apply; no pointer register SHALL exist.

Verification
REQ-039 Reset, then 3 loader writes to addr 0,1,2 (0x00000013, 0x00100093, 0x00208113), then ld_done_i -> ld_gnt_o 1 each cycle, ld_cnt_o=3, boot_done_o=1 the next cycle.
REQ-040 In BOOT, fetch_req_i=1 at addr 0 for 4 cycles -> fetch_gnt_o stays 0 and fetch_rvalid_o stays 0.
REQ-041 RUN, fetch addr 0,1,2 on consecutive cycles -> fetch_rvalid_o high for cycles 2-4, data 0x00000013, 0x00100093, 0x00208113.
REQ-042 RUN, both requesting for 4 cycles -> without macro, grants F,F,F,F; with RV_IMEM_ARB_RR_EN, grants F,L,F,L.
REQ-043 Loader writes 40 words -> ld_cnt_o saturates at 32.
REQ-044 rst_n_i pulled low in the cycle after a fetch grant -> fetch_rvalid_o=0 at once, state BOOT, ld_cnt_o=0.
